mc_prob_controller: RTL and testbench

MC_PROB_CONTROLLER -- requirements
Module: mc_prob_controller

---
 rtl/mc_prob_controller.sv | 181 ++++++++++++++++++
 tb/tb_mc_prob_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_prob_controller.sv
// Monte-Carlo batch controller: launches N engine runs, counts successes, then
// divides to p = floor(succ*SCALE/N). Define MC_LFSR_SEED_EN for LFSR seed stepping.
module mc_prob_controller #(
  parameter  int CNT_W  = 8,
  parameter  int SEED_W = 23,
  parameter  int SCALE  = 100,
  localparam int P_W    = $clog2(SCALE + 1),
  localparam int PROD_W = CNT_W + P_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  n_runs,
  input  logic [SEED_W-1:0] seed_base,
  output logic              sim_start,
  output logic [SEED_W-1:0] sim_seed,
  input  logic              sim_done,
  input  logic              sim_y,
  output logic [CNT_W-1:0]  runs_cnt,
  output logic [CNT_W-1:0]  succ_cnt,
  output logic [P_W-1:0]    p,
  output logic              busy,
  output logic              done
);

  localparam int DC_W = $clog2(PROD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_DIVIDE, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic [CNT_W-1:0]    runs_q, runs_d;
  logic [CNT_W-1:0]    succ_q, succ_d;
  logic [P_W-1:0]      p_q, p_d;
  logic [PROD_W-1:0]   dq_q, dq_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [DC_W-1:0]     dc_q, dc_d;

  logic                last_run;
  logic                div_last;
  logic [CNT_W-1:0]    succ_inc;
  logic [PROD_W-1:0]   prod;
  logic [CNT_W:0]      rem_sh;
  logic [CNT_W:0]      rem_sub;
  logic                q_bit;
  logic [SEED_W-1:0]   seed_init;
  logic [SEED_W-1:0]   seed_next;

`ifdef MC_LFSR_SEED_EN
  // An all-zero LFSR state would lock up, so a zero base is promoted to 1.
  assign seed_init = (seed_base == '0) ? SEED_W'(1) : seed_base;
  assign seed_next = {seed_q[SEED_W-2:0], seed_q[SEED_W-1] ^ seed_q[SEED_W-6]};
`else
  assign seed_init = seed_base;
  assign seed_next = seed_q + SEED_W'(1);
`endif

  assign last_run = ({1'b0, runs_q} + (CNT_W+1)'(1)) == {1'b0, n_q};
  assign div_last = dc_q == DC_W'(PROD_W - 1);
  assign succ_inc = succ_q + CNT_W'(sim_y);
  assign prod     = PROD_W'(succ_inc) * PROD_W'(SCALE);

  // Restoring step: dq_q holds dividend bits in its top, quotient bits shift in below.
  assign rem_sh  = {rem_q, dq_q[PROD_W-1]};
  assign q_bit   = rem_sh >= {1'b0, n_q};
  assign rem_sub = rem_sh - {1'b0, n_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= '0;
      seed_q <= '0;
      runs_q <= '0;
      succ_q <= '0;
      p_q    <= '0;
      dq_q   <= '0;
      rem_q  <= '0;
      dc_q   <= '0;
    end else begin
      n_q    <= n_d;
      seed_q <= seed_d;
      runs_q <= runs_d;
      succ_q <= succ_d;
      p_q    <= p_d;
      dq_q   <= dq_d;
      rem_q  <= rem_d;
      dc_q   <= dc_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (n_runs == '0) ? S_DIVIDE : S_LAUNCH;
      end
      S_LAUNCH: state_d = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort)         state_d = S_IDLE;
        else if (sim_done) state_d = last_run ? S_DIVIDE : S_LAUNCH;
      end
      S_DIVIDE: begin
        if (abort)                         state_d = S_IDLE;
        else if (n_q == '0 || div_last)    state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    n_d    = n_q;
    seed_d = seed_q;
    runs_d = runs_q;
    succ_d = succ_q;
    p_d    = p_q;
    dq_d   = dq_q;
    rem_d  = rem_q;
    dc_d   = dc_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d    = n_runs;
          seed_d = seed_init;
          runs_d = '0;
          succ_d = '0;
          p_d    = '0;
          dq_d   = '0;
          rem_d  = '0;
          dc_d   = '0;
        end
      end
      S_WAIT: begin
        if (!abort && sim_done) begin
          runs_d = runs_q + CNT_W'(1);
          succ_d = succ_inc;
          seed_d = seed_next;
          dq_d   = prod;
          rem_d  = '0;
          dc_d   = '0;
        end
      end
      S_DIVIDE: begin
        if (!abort && n_q != '0) begin
          dq_d  = {dq_q[PROD_W-2:0], q_bit};
          rem_d = q_bit ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
          dc_d  = dc_q + DC_W'(1);
          // succ <= N bounds the quotient by SCALE, so it fits in P_W bits.
          if (div_last) p_d = dq_d[P_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sim_start = (state_q == S_LAUNCH);
    busy      = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_DIVIDE);
    done      = (state_q == S_DONE);
  end

  assign sim_seed = seed_q;
  assign runs_cnt = runs_q;
  assign succ_cnt = succ_q;
  assign p        = p_q;

endmodule

// File: tb/tb_mc_prob_controller.sv
// Self-checking bench for mc_prob_controller: an engine model answers each launch,
// and expected seeds, counts and p come from plain arithmetic on the run outcomes.
module tb_mc_prob_controller;

  localparam int DIV_CYCLES = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [7:0]  n_runs;
  logic [22:0] seed_base;
  logic        sim_start;
  logic [22:0] sim_seed;
  logic        sim_done, sim_y;
  logic [7:0]  runs_cnt, succ_cnt;
  logic [6:0]  p;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;
  logic y_pat [256];

  mc_prob_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .n_runs    (n_runs),
    .seed_base (seed_base),
    .sim_start (sim_start),
    .sim_seed  (sim_seed),
    .sim_done  (sim_done),
    .sim_y     (sim_y),
    .runs_cnt  (runs_cnt),
    .succ_cnt  (succ_cnt),
    .p         (p),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] seed_first(input logic [22:0] sb);
`ifdef MC_LFSR_SEED_EN
    return (sb == 23'd0) ? 23'd1 : sb;
`else
    return sb;
`endif
  endfunction

  function automatic logic [22:0] seed_step(input logic [22:0] s);
`ifdef MC_LFSR_SEED_EN
    return {s[21:0], s[22] ^ s[17]};
`else
    return s + 23'd1;
`endif
  endfunction

  task automatic idle_outputs_zero(input string tag);
    check({tag, "_sim_start"}, sim_start, 0);
    check({tag, "_sim_seed"},  sim_seed,  0);
    check({tag, "_runs"},      runs_cnt,  0);
    check({tag, "_succ"},      succ_cnt,  0);
    check({tag, "_p"},         p,         0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
  endtask

  // Runs one batch of n using y_pat[] as engine outcomes; abort_after>0 aborts
  // in the launch following that many completed runs. Called #1 after a rising edge.
  task automatic run_batch(input int n, input logic [22:0] sb, input int abort_after);
    logic [22:0] es;
    int succ, cyc, dly, exp_p;
    es   = seed_first(sb);
    succ = 0;
    start = 1'b1; n_runs = 8'(n); seed_base = sb;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_dropped", done, 0);
    for (int k = 0; k < n; k++) begin
      check("sim_start_hi", sim_start, 1);
      check("sim_seed", sim_seed, es);
      @(posedge clk); #1;
      check("sim_start_one_cycle", sim_start, 0);
      if (k == 0) begin
        start = 1'b1; n_runs = 8'(n + 3);
        @(posedge clk); #1;
        start = 1'b0;
      end
      dly = $urandom_range(0, 3);
      repeat (dly) begin @(posedge clk); #1; end
      check("seed_stable", sim_seed, es);
      sim_done = 1'b1; sim_y = y_pat[k];
      @(posedge clk); #1;
      sim_done = 1'b0; sim_y = 1'b0;
      succ += int'(y_pat[k]);
      es = seed_step(es);
      check("runs_cnt", runs_cnt, k + 1);
      check("succ_cnt", succ_cnt, succ);
      if (k + 1 == abort_after) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sim_start", sim_start, 0);
        check("abort_runs_held", runs_cnt, k + 1);
        sim_done = 1'b1; sim_y = 1'b1;
        @(posedge clk); #1;
        sim_done = 1'b0; sim_y = 1'b0;
        check("late_done_runs", runs_cnt, k + 1);
        check("late_done_succ", succ_cnt, succ);
        check("late_done_busy", busy, 0);
        return;
      end
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      check("no_launch_in_divide", sim_start, 0);
      @(posedge clk); #1;
      cyc++;
    end
    if (n == 0) check("n0_done_within_3", (cyc <= 3), 1);
    else        check("divide_cycles", cyc, DIV_CYCLES);
    exp_p = (n == 0) ? 0 : (succ * 100) / n;
    check("p", p, exp_p);
    check("final_runs", runs_cnt, n);
    check("final_succ", succ_cnt, succ);
    check("final_busy", busy, 0);
    check("final_done", done, 1);
    sim_done = 1'b1; sim_y = 1'b1;
    @(posedge clk); #1;
    sim_done = 1'b0; sim_y = 1'b0;
    check("hold_runs", runs_cnt, n);
    check("hold_succ", succ_cnt, succ);
    check("hold_p", p, exp_p);
    check("hold_done", done, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    n_runs = '0; seed_base = '0; sim_done = 1'b0; sim_y = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: N=4, outcomes 1,0,1,1 -> p=75
    y_pat[0] = 1; y_pat[1] = 0; y_pat[2] = 1; y_pat[3] = 1;
    run_batch(4, 23'd1, 0);

    // N=0: no launch, p=0
    run_batch(0, 23'($urandom), 0);

    // N=127 with 50 successes -> p=39
    for (int i = 0; i < 127; i++) y_pat[i] = (i < 50);
    run_batch(127, 23'd10, 0);

    // Seed wrap-around
    for (int i = 0; i < 2; i++) y_pat[i] = 1'($urandom);
    run_batch(2, 23'h7FFFFF, 0);

    // Abort after second completion, then a clean batch
    for (int i = 0; i < 3; i++) y_pat[i] = 1'($urandom);
    run_batch(3, 23'd100, 2);
    run_batch(3, 23'd200, 0);

    // Reset while waiting on the engine
    start = 1'b1; n_runs = 8'd5; seed_base = 23'd77;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    sim_done = 1'b1; sim_y = 1'b1;
    @(posedge clk); #1;
    sim_done = 1'b0; sim_y = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_runs", runs_cnt, 1);
    rst_n = 1'b0;
    #1;
    idle_outputs_zero("midrun_reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    sim_done = 1'b1; sim_y = 1'b1;
    @(posedge clk); #1;
    sim_done = 1'b0; sim_y = 1'b0;
    check("post_reset_ignored_runs", runs_cnt, 0);
    check("post_reset_ignored_busy", busy, 0);
    for (int i = 0; i < 5; i++) y_pat[i] = 1'($urandom);
    run_batch(5, 23'd300, 0);

    // Boundaries: full-scale and zero-success
    for (int i = 0; i < 255; i++) y_pat[i] = 1'b1;
    run_batch(255, 23'($urandom), 0);
    y_pat[0] = 1'b0;
    run_batch(1, 23'($urandom), 0);

    // Randomized batches
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) y_pat[i] = 1'($urandom);
      run_batch(n, 23'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
